// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-sequencer bundle: instruction-memory port, decode handshake, redirect and PC status.
// The master modport is the sequencer side; the slave modport is the memory/decode/next-PC side.
interface pc_fetch_sequencer_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemValid;
  logic [31:0] imemRdata;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instrOut;
  logic [31:0] instrPc;
  logic [31:0] instrPcPlus8;
  logic        redirect;
  logic [31:0] redirectTarget;
  logic [31:0] pcOut;
  logic        alignFault;

  modport master (
    output imemReq, imemAddr, instrValid, instrOut, instrPc, instrPcPlus8, pcOut, alignFault,
    input  imemGnt, imemValid, imemRdata, instrReady, redirect, redirectTarget
  );

  modport slave (
    input  imemReq, imemAddr, instrValid, instrOut, instrPc, instrPcPlus8, pcOut, alignFault,
    output imemGnt, imemValid, imemRdata, instrReady, redirect, redirectTarget
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Fetch PC owner: single-outstanding req/gnt/valid fetch, decode valid/ready hand-off, redirects.
// Define PC_SEQ_MISALIGN_TRAP_EN to trap misaligned redirect targets into a sticky FAULT state.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                     clock,
  input logic                     reset,
  pc_fetch_sequencer_if.master    bus
);

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {StIdle, StReq, StWait, StDrain, StHold, StFault} state_e;
`else
  typedef enum logic [2:0] {StIdle, StReq, StWait, StDrain, StHold} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] target_aligned;

  assign target_aligned = bus.redirectTarget & 32'hFFFF_FFFC;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  logic align_fault_q, align_fault_d;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      align_fault_q <= 1'b0;
    end else begin
      align_fault_q <= align_fault_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    align_fault_d = align_fault_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.redirect) pc_d = target_aligned;
        state_d = StReq;
      end
      StReq: begin
        if (bus.redirect) pc_d = target_aligned;
        // A granted request whose address was just redirected must still be drained.
        if (bus.imemGnt) state_d = bus.redirect ? StDrain : StWait;
      end
      StWait: begin
        if (bus.imemValid) begin
          if (bus.redirect) begin
            pc_d    = target_aligned;
            state_d = StReq;
          end else begin
            instr_d    = bus.imemRdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = StHold;
          end
        end else if (bus.redirect) begin
          pc_d    = target_aligned;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (bus.redirect) pc_d = target_aligned;
        if (bus.imemValid) state_d = StReq;
      end
      StHold: begin
        if (bus.redirect) begin
          pc_d    = target_aligned;
          state_d = StReq;
        end else if (bus.instrReady) begin
          state_d = StReq;
        end
      end
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      StFault: begin
      end
`endif
      default: state_d = StIdle;
    endcase

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    // Misaligned redirect overrides every state's decision; FAULT is left only by reset.
    if (bus.redirect && (bus.redirectTarget[1:0] != 2'b00) && (state_q != StFault)) begin
      pc_d          = target_aligned;
      state_d       = StFault;
      align_fault_d = 1'b1;
    end
`endif
  end

  assign bus.imemReq      = (state_q == StReq);
  assign bus.imemAddr     = pc_q;
  assign bus.pcOut        = pc_q;
  assign bus.instrValid   = (state_q == StHold);
  assign bus.instrOut     = instr_q;
  assign bus.instrPc      = instr_pc_q;
  assign bus.instrPcPlus8 = instr_pc_q + 32'd8;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
  assign bus.alignFault   = align_fault_q;
`else
  assign bus.alignFault   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: streaming, backpressure, redirects, wrap, misalign, reset.
module tb_pc_fetch_sequencer;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  pc_fetch_sequencer_if bus();

  pc_fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imemGnt        = 1'b0;
    bus.imemValid      = 1'b0;
    bus.imemRdata      = 32'h0;
    bus.instrReady     = 1'b0;
    bus.redirect       = 1'b0;
    bus.redirectTarget = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    checks++; if (bus.imemReq !== 1'b0) begin failures++;
      $display("FAIL rst_req got %h exp 0", bus.imemReq); end
    checks++; if (bus.instrValid !== 1'b0) begin failures++;
      $display("FAIL rst_valid got %h exp 0", bus.instrValid); end
    checks++; if (bus.pcOut !== 32'h0) begin failures++;
      $display("FAIL rst_pc got %h exp 0", bus.pcOut); end
    checks++; if (bus.instrOut !== 32'h0) begin failures++;
      $display("FAIL rst_instr got %h exp 0", bus.instrOut); end
    checks++; if (bus.instrPc !== 32'h0) begin failures++;
      $display("FAIL rst_instr_pc got %h exp 0", bus.instrPc); end
    checks++; if (bus.alignFault !== 1'b0) begin failures++;
      $display("FAIL rst_fault got %h exp 0", bus.alignFault); end
    checks++; if (bus.instrPcPlus8 !== 32'h8) begin failures++;
      $display("FAIL rst_plus8 got %h exp 8", bus.instrPcPlus8); end
    reset = 1'b0;
    #1;
    checks++; if (bus.imemReq !== 1'b0) begin failures++;
      $display("FAIL idle_req got %h exp 0", bus.imemReq); end
    step();
    checks++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h0) begin failures++;
      $display("FAIL first_req got req=%h addr=%h exp req=1 addr=0", bus.imemReq, bus.imemAddr); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] addr;
      logic [31:0] word;
      addr = 32'(i * 4);
      word = 32'hE3A0_1000 + 32'(i);
      checks++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== addr) begin failures++;
        $display("FAIL stream_req%0d got req=%h addr=%h exp req=1 addr=%h",
                 i, bus.imemReq, bus.imemAddr, addr); end
      bus.imemGnt = 1'b1;
      bus.instrReady = 1'b1;
      step();
      checks++; if (bus.imemReq !== 1'b0 || bus.instrValid !== 1'b0) begin failures++;
        $display("FAIL stream_wait%0d got req=%h valid=%h exp 0/0", i, bus.imemReq,
                 bus.instrValid); end
      bus.imemGnt = 1'b0;
      bus.imemValid = 1'b1;
      bus.imemRdata = word;
      step();
      bus.imemValid = 1'b0;
      bus.imemRdata = 32'h0;
      checks++; if (bus.instrValid !== 1'b1 || bus.instrOut !== word) begin failures++;
        $display("FAIL stream_instr%0d got v=%h w=%h exp v=1 w=%h", i, bus.instrValid,
                 bus.instrOut, word); end
      checks++; if (bus.instrPc !== addr || bus.instrPcPlus8 !== addr + 32'd8) begin failures++;
        $display("FAIL stream_pc%0d got pc=%h p8=%h exp pc=%h p8=%h", i, bus.instrPc,
                 bus.instrPcPlus8, addr, addr + 32'd8); end
      step();
    end
  endtask

  task automatic test_backpressure();
    bus.instrReady = 1'b0;
    checks++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'hC) begin failures++;
      $display("FAIL bp_req got req=%h addr=%h exp 1/c", bus.imemReq, bus.imemAddr); end
    bus.imemGnt = 1'b1;
    step();
    bus.imemGnt = 1'b0;
    bus.imemValid = 1'b1;
    bus.imemRdata = 32'hE592_0004;
    step();
    bus.imemValid = 1'b0;
    bus.imemRdata = 32'h0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.instrValid !== 1'b1 || bus.instrOut !== 32'hE592_0004 ||
                    bus.instrPc !== 32'hC || bus.imemReq !== 1'b0) begin failures++;
        $display("FAIL bp_hold%0d got v=%h w=%h pc=%h req=%h exp 1/e5920004/c/0", k,
                 bus.instrValid, bus.instrOut, bus.instrPc, bus.imemReq); end
      step();
    end
    bus.instrReady = 1'b1;
    checks++; if (bus.instrValid !== 1'b1 || bus.imemReq !== 1'b0) begin failures++;
      $display("FAIL bp_accept got v=%h req=%h exp 1/0", bus.instrValid, bus.imemReq); end
    step();
    checks++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h10 || bus.instrValid !== 1'b0)
    begin failures++;
      $display("FAIL bp_next got req=%h addr=%h v=%h exp 1/10/0", bus.imemReq, bus.imemAddr,
               bus.instrValid); end
  endtask

  task automatic test_redirect_wait();
    bus.imemGnt = 1'b1;
    step();
    bus.imemGnt = 1'b0;
    bus.redirect = 1'b1;
    bus.redirectTarget = 32'h100;
    step();
    bus.redirect = 1'b0;
    checks++; if (bus.pcOut !== 32'h100 || bus.imemReq !== 1'b0 || bus.instrValid !== 1'b0)
    begin failures++;
      $display("FAIL rw_drain got pc=%h req=%h v=%h exp 100/0/0", bus.pcOut, bus.imemReq,
               bus.instrValid); end
    step();
    step();
    checks++; if (bus.imemReq !== 1'b0 || bus.instrValid !== 1'b0) begin failures++;
      $display("FAIL rw_drain2 got req=%h v=%h exp 0/0", bus.imemReq, bus.instrValid); end
    bus.imemValid = 1'b1;
    bus.imemRdata = 32'hBAD0_0010;
    step();
    bus.imemValid = 1'b0;
    checks++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h100 || bus.instrValid !== 1'b0)
    begin failures++;
      $display("FAIL rw_req got req=%h addr=%h v=%h exp 1/100/0", bus.imemReq, bus.imemAddr,
               bus.instrValid); end
  endtask

  task automatic test_redirect_gnt();
    bus.redirect = 1'b1;
    bus.redirectTarget = 32'h10;
    step();
    checks++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h10) begin failures++;
      $display("FAIL rg_req_move got req=%h addr=%h exp 1/10", bus.imemReq, bus.imemAddr); end
    bus.imemGnt = 1'b1;
    bus.redirectTarget = 32'h200;
    step();
    bus.imemGnt = 1'b0;
    bus.redirect = 1'b0;
    checks++; if (bus.imemReq !== 1'b0 || bus.pcOut !== 32'h200) begin failures++;
      $display("FAIL rg_drain got req=%h pc=%h exp 0/200", bus.imemReq, bus.pcOut); end
    bus.imemValid = 1'b1;
    bus.imemRdata = 32'hBAD0_0010;
    step();
    bus.imemValid = 1'b0;
    checks++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h200 || bus.instrValid !== 1'b0)
    begin failures++;
      $display("FAIL rg_req got req=%h addr=%h v=%h exp 1/200/0", bus.imemReq, bus.imemAddr,
               bus.instrValid); end
    bus.imemGnt = 1'b1;
    step();
    bus.imemGnt = 1'b0;
    bus.imemValid = 1'b1;
    bus.imemRdata = 32'hE1A0_0200;
    step();
    bus.imemValid = 1'b0;
    checks++; if (bus.instrOut !== 32'hE1A0_0200 || bus.instrPc !== 32'h200) begin failures++;
      $display("FAIL rg_instr got w=%h pc=%h exp e1a00200/200", bus.instrOut, bus.instrPc); end
    bus.instrReady = 1'b1;
    step();
  endtask

  task automatic test_wrap();
    bus.redirect = 1'b1;
    bus.redirectTarget = 32'hFFFF_FFFC;
    step();
    bus.redirect = 1'b0;
    checks++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'hFFFF_FFFC) begin failures++;
      $display("FAIL wrap_req got req=%h addr=%h exp 1/fffffffc", bus.imemReq, bus.imemAddr); end
    bus.imemGnt = 1'b1;
    step();
    bus.imemGnt = 1'b0;
    bus.imemValid = 1'b1;
    bus.imemRdata = 32'hE320_F000;
    step();
    bus.imemValid = 1'b0;
    checks++; if (bus.instrPc !== 32'hFFFF_FFFC || bus.instrPcPlus8 !== 32'h4 ||
                  bus.pcOut !== 32'h0) begin failures++;
      $display("FAIL wrap_pc got pc=%h p8=%h next=%h exp fffffffc/4/0", bus.instrPc,
               bus.instrPcPlus8, bus.pcOut); end
    step();
    checks++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h0) begin failures++;
      $display("FAIL wrap_next got req=%h addr=%h exp 1/0", bus.imemReq, bus.imemAddr); end
  endtask

  task automatic test_hold_redirect();
    bus.instrReady = 1'b0;
    bus.imemGnt = 1'b1;
    step();
    bus.imemGnt = 1'b0;
    bus.imemValid = 1'b1;
    bus.imemRdata = 32'hEAFF_FFFE;
    step();
    bus.imemValid = 1'b0;
    bus.redirect = 1'b1;
    bus.redirectTarget = 32'h300;
    step();
    bus.redirect = 1'b0;
    checks++; if (bus.instrValid !== 1'b0 || bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h300)
    begin failures++;
      $display("FAIL hr_hold got v=%h req=%h addr=%h exp 0/1/300", bus.instrValid, bus.imemReq,
               bus.imemAddr); end
    bus.imemGnt = 1'b1;
    step();
    bus.imemGnt = 1'b0;
    bus.imemValid = 1'b1;
    bus.imemRdata = 32'hBAD0_0300;
    bus.redirect = 1'b1;
    bus.redirectTarget = 32'h400;
    step();
    bus.imemValid = 1'b0;
    bus.redirect = 1'b0;
    checks++; if (bus.instrValid !== 1'b0 || bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h400)
    begin failures++;
      $display("FAIL hr_wait got v=%h req=%h addr=%h exp 0/1/400", bus.instrValid, bus.imemReq,
               bus.imemAddr); end
  endtask

  task automatic test_misalign();
    bus.redirect = 1'b1;
    bus.redirectTarget = 32'h102;
    step();
    bus.redirect = 1'b0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    checks++; if (bus.alignFault !== 1'b1 || bus.imemReq !== 1'b0 || bus.pcOut !== 32'h100)
    begin failures++;
      $display("FAIL ma_fault got f=%h req=%h pc=%h exp 1/0/100", bus.alignFault, bus.imemReq,
               bus.pcOut); end
    bus.imemGnt = 1'b1;
    bus.imemValid = 1'b1;
    bus.instrReady = 1'b1;
    bus.redirect = 1'b1;
    bus.redirectTarget = 32'h500;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (bus.alignFault !== 1'b1 || bus.imemReq !== 1'b0 ||
                    bus.instrValid !== 1'b0 || bus.pcOut !== 32'h100) begin failures++;
        $display("FAIL ma_sticky%0d got f=%h req=%h v=%h pc=%h exp 1/0/0/100", k,
                 bus.alignFault, bus.imemReq, bus.instrValid, bus.pcOut); end
    end
    idle_inputs();
    reset = 1'b1;
    #1;
    checks++; if (bus.alignFault !== 1'b0 || bus.pcOut !== 32'h0) begin failures++;
      $display("FAIL ma_reset got f=%h pc=%h exp 0/0", bus.alignFault, bus.pcOut); end
    step();
    reset = 1'b0;
    step();
    checks++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h0) begin failures++;
      $display("FAIL ma_restart got req=%h addr=%h exp 1/0", bus.imemReq, bus.imemAddr); end
`else
    checks++; if (bus.alignFault !== 1'b0 || bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h100)
    begin failures++;
      $display("FAIL ma_clear got f=%h req=%h addr=%h exp 0/1/100", bus.alignFault,
               bus.imemReq, bus.imemAddr); end
    bus.imemGnt = 1'b1;
    step();
    bus.imemGnt = 1'b0;
    bus.imemValid = 1'b1;
    bus.imemRdata = 32'hE1A0_0100;
    step();
    bus.imemValid = 1'b0;
    checks++; if (bus.instrValid !== 1'b1 || bus.instrPc !== 32'h100) begin failures++;
      $display("FAIL ma_fetch got v=%h pc=%h exp 1/100", bus.instrValid, bus.instrPc); end
    bus.instrReady = 1'b1;
    step();
`endif
  endtask

  task automatic test_reset_mid_wait();
    bus.imemGnt = 1'b1;
    step();
    bus.imemGnt = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.imemReq !== 1'b0 || bus.instrValid !== 1'b0 || bus.pcOut !== 32'h0 ||
                  bus.imemAddr !== 32'h0) begin failures++;
      $display("FAIL rm_ctrl got req=%h v=%h pc=%h addr=%h exp 0/0/0/0", bus.imemReq,
               bus.instrValid, bus.pcOut, bus.imemAddr); end
    checks++; if (bus.instrOut !== 32'h0 || bus.instrPc !== 32'h0 || bus.alignFault !== 1'b0)
    begin failures++;
      $display("FAIL rm_data got w=%h pc=%h f=%h exp 0/0/0", bus.instrOut, bus.instrPc,
               bus.alignFault); end
    bus.imemValid = 1'b1;
    bus.imemRdata = 32'hBAD0_0BAD;
    step();
    reset = 1'b0;
    step();
    checks++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h0 || bus.instrValid !== 1'b0)
    begin failures++;
      $display("FAIL rm_req got req=%h addr=%h v=%h exp 1/0/0", bus.imemReq, bus.imemAddr,
               bus.instrValid); end
    step();
    checks++; if (bus.imemReq !== 1'b1 || bus.instrValid !== 1'b0) begin failures++;
      $display("FAIL rm_stale got req=%h v=%h exp 1/0", bus.imemReq, bus.instrValid); end
    bus.imemValid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_gnt();
    test_wrap();
    test_hold_redirect();
    test_misalign();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
